y86_stage_sequencer: RTL and testbench

- Multi-cycle controller for the Y86-64 core.
- Owns the architectural PC register and steps the existing datapath stages in order: fetch, decode, execute, memory, write-back, PC update.
- Performs the PC-select function in its PC-update state, and handshakes with the instruction and data memories, which may insert wait states.
- Drives the processor status code and retirement/cycle counters read by the top level and benches.

---
 rtl/y86_stage_sequencer_pkg.sv | 45 ++++
 rtl/y86_stage_sequencer_if.sv | 39 +++
 rtl/y86_pc_select.sv | 23 ++
 rtl/y86_stage_sequencer.sv | 149 ++++++++++++++
 tb/tb_y86_stage_sequencer.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/y86_stage_sequencer_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, sequencer states
// and per-stage enable encodings.
package y86_stage_sequencer_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [4:0] EN_F = 5'b00001;
  localparam logic [4:0] EN_D = 5'b00010;
  localparam logic [4:0] EN_E = 5'b00100;
  localparam logic [4:0] EN_M = 5'b01000;
  localparam logic [4:0] EN_W = 5'b10000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPD,
    S_HALT,
    S_FAULT
  } state_t;

  function automatic logic uses_mem(input logic [3:0] icode);
    return icode inside {IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ};
  endfunction

endpackage

// File: rtl/y86_stage_sequencer_if.sv
// Handshake and status bundle between the stage sequencer (master) and the
// fetch/execute datapath plus memories (slave).
interface y86_stage_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             start_i;
  logic [3:0]       icode_i;
  logic             instr_valid_i;
  logic             imem_ack_i;
  logic             imem_error_i;
  logic             dmem_ack_i;
  logic             dmem_error_i;
  logic             cnd_i;
  logic [63:0]      valC_i;
  logic [63:0]      valM_i;
  logic [63:0]      valP_i;
  logic [63:0]      PC_o;
  logic             imem_req_o;
  logic             dmem_req_o;
  logic [4:0]       stage_en_o;
  logic [2:0]       stat_o;
  logic             busy_o;
  logic [CNT_W-1:0] cycle_cnt_o;
  logic [CNT_W-1:0] retired_o;

  modport master (
    input  start_i, icode_i, instr_valid_i, imem_ack_i, imem_error_i,
           dmem_ack_i, dmem_error_i, cnd_i, valC_i, valM_i, valP_i,
    output PC_o, imem_req_o, dmem_req_o, stage_en_o, stat_o, busy_o,
           cycle_cnt_o, retired_o
  );

  modport slave (
    output start_i, icode_i, instr_valid_i, imem_ack_i, imem_error_i,
           dmem_ack_i, dmem_error_i, cnd_i, valC_i, valM_i, valP_i,
    input  PC_o, imem_req_o, dmem_req_o, stage_en_o, stat_o, busy_o,
           cycle_cnt_o, retired_o
  );
endinterface

// File: rtl/y86_pc_select.sv
// Combinational next-PC mux used in the PC-update state.
module y86_pc_select
  import y86_stage_sequencer_pkg::*;
(
  input  logic [3:0]  icode,
  input  logic        cnd,
  input  logic [63:0] valC,
  input  logic [63:0] valM,
  input  logic [63:0] valP,
  output logic [63:0] new_pc
);

  always_comb begin
    new_pc = valP;
    if (icode == ICALL)
      new_pc = valC;
    else if (icode == IJXX && cnd)
      new_pc = valC;
    else if (icode == IRET)
      new_pc = valM;
  end

endmodule

// File: rtl/y86_stage_sequencer.sv
// Multi-cycle Y86-64 controller: owns the PC, steps F/D/E/M/W/PC-update,
// handshakes with both memories and reports status and counters.
module y86_stage_sequencer
  import y86_stage_sequencer_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          CNT_W       = 32,
  parameter int          MEM_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  y86_stage_sequencer_if.master   bus
);

  localparam logic [31:0] WAIT_LIMIT = 32'(MEM_TIMEOUT - 1);

  state_t           state, state_n;
  logic [63:0]      pc;
  logic [63:0]      new_pc;
  logic [2:0]       stat, stat_n;
  logic [3:0]       icode_q;
  logic [CNT_W-1:0] cycle_cnt, retired;
  logic [31:0]      wait_cnt;
  logic             wait_inc;
  logic             wait_hit;
  logic             imem_req, dmem_req, busy;
  logic [4:0]       stage_en;

  y86_pc_select u_pc_select (
    .icode  (icode_q),
    .cnd    (bus.cnd_i),
    .valC   (bus.valC_i),
    .valM   (bus.valM_i),
    .valP   (bus.valP_i),
    .new_pc (new_pc)
  );

  always_comb begin
    state_n  = state;
    stat_n   = stat;
    wait_inc = 1'b0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    stage_en = '0;
    busy     = 1'b1;
    wait_hit = (wait_cnt == WAIT_LIMIT);
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (bus.start_i) state_n = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        stage_en = EN_F;
        // Error beats ack; decode checks use the live icode, later states the latched copy.
        if (bus.imem_ack_i) begin
          if (bus.imem_error_i) begin
            state_n = S_FAULT;
            stat_n  = SADR;
          end else if (!bus.instr_valid_i || bus.icode_i > IPOPQ) begin
            state_n = S_FAULT;
            stat_n  = SINS;
          end else if (bus.icode_i == IHALT) begin
            state_n = S_HALT;
            stat_n  = SHLT;
          end else begin
            state_n = S_DECODE;
          end
        end else if (wait_hit) begin
          state_n = S_FAULT;
          stat_n  = SADR;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_DECODE: begin
        stage_en = EN_D;
        state_n  = S_EXECUTE;
      end
      S_EXECUTE: begin
        stage_en = EN_E;
        state_n  = uses_mem(icode_q) ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        dmem_req = 1'b1;
        stage_en = EN_M;
        if (bus.dmem_ack_i) begin
          if (bus.dmem_error_i) begin
            state_n = S_FAULT;
            stat_n  = SADR;
          end else begin
            state_n = S_WRITEBACK;
          end
        end else if (wait_hit) begin
          state_n = S_FAULT;
          stat_n  = SADR;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_WRITEBACK: begin
        stage_en = EN_W;
        state_n  = S_PCUPD;
      end
      S_PCUPD: begin
        state_n = S_FETCH;
      end
      S_HALT, S_FAULT: begin
        busy = 1'b0;
      end
      default: begin
        busy    = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      stat      <= SAOK;
      icode_q   <= '0;
      cycle_cnt <= '0;
      retired   <= '0;
      wait_cnt  <= '0;
    end else begin
      state    <= state_n;
      stat     <= stat_n;
      wait_cnt <= wait_inc ? wait_cnt + 32'd1 : '0;
      if (busy) cycle_cnt <= cycle_cnt + 1'b1;
      if (state == S_FETCH && bus.imem_ack_i) icode_q <= bus.icode_i;
      if (state == S_PCUPD) begin
        pc      <= new_pc;
        retired <= retired + 1'b1;
      end
    end
  end

  assign bus.PC_o        = pc;
  assign bus.imem_req_o  = imem_req;
  assign bus.dmem_req_o  = dmem_req;
  assign bus.stage_en_o  = stage_en;
  assign bus.stat_o      = stat;
  assign bus.busy_o      = busy;
  assign bus.cycle_cnt_o = cycle_cnt;
  assign bus.retired_o   = retired;

endmodule

// File: tb/tb_y86_stage_sequencer.sv
// Directed bench for y86_stage_sequencer: a PC scoreboard filled at issue and
// drained on each retirement, plus cycle-level checks of handshakes and faults.
module tb_y86_stage_sequencer;
  import y86_stage_sequencer_pkg::*;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] prev_ret = '0;

  y86_stage_sequencer_if #(.CNT_W(32)) bus ();

  y86_stage_sequencer #(
    .RESET_PC    (64'h0),
    .CNT_W       (32),
    .MEM_TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard drain: every retirement must match the oldest issued PC.
  always @(negedge clk) begin
    if (!rst && bus.retired_o == prev_ret + 32'd1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_retire", 64'd0, 64'd1);
      end else begin
        check("sb_pc", bus.PC_o, exp_q.pop_front());
      end
    end
    prev_ret = bus.retired_o;
  end

  // Entered in the first FETCH cycle; leaves in the next FETCH cycle.
  task automatic run_instr(input logic [3:0] icode, input logic cnd,
                           input logic [63:0] valc, input logic [63:0] valm,
                           input logic [63:0] valp, input int iwait,
                           input int dwait, input logic [63:0] exp_pc);
    logic [31:0] c0;
    int dreq;
    logic mem;
    mem = icode inside {IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ};
    c0 = bus.cycle_cnt_o;
    dreq = 0;
    bus.icode_i = icode;
    bus.cnd_i   = cnd;
    bus.valC_i  = valc;
    bus.valM_i  = valm;
    bus.valP_i  = valp;
    exp_q.push_back(exp_pc);
    for (int i = 0; i < iwait; i++) begin
      check("fetch_wait_req", {63'd0, bus.imem_req_o}, 64'd1);
      tick();
    end
    bus.imem_ack_i = 1'b1;
    check("en_fetch", {59'd0, bus.stage_en_o}, {59'd0, EN_F});
    tick();
    bus.imem_ack_i = 1'b0;
    check("en_decode", {59'd0, bus.stage_en_o}, {59'd0, EN_D});
    tick();
    check("en_execute", {59'd0, bus.stage_en_o}, {59'd0, EN_E});
    tick();
    if (mem) begin
      for (int i = 0; i < dwait; i++) begin
        if (bus.dmem_req_o === 1'b1) dreq++;
        check("en_memory_wait", {59'd0, bus.stage_en_o}, {59'd0, EN_M});
        tick();
      end
      bus.dmem_ack_i = 1'b1;
      if (bus.dmem_req_o === 1'b1) dreq++;
      tick();
      bus.dmem_ack_i = 1'b0;
      check("dmem_req_cycles", 64'(dreq), 64'(dwait + 1));
    end
    check("en_writeback", {59'd0, bus.stage_en_o}, {59'd0, EN_W});
    tick();
    check("en_pcupd", {59'd0, bus.stage_en_o}, 64'd0);
    tick();
    check("pc_after", bus.PC_o, exp_pc);
    check("latency", 64'(bus.cycle_cnt_o - c0), 64'(5 + iwait + (mem ? 1 + dwait : 0)));
  endtask

  task automatic start_run();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
  endtask

  initial begin
    logic [31:0] c_hold;
    int n;
    bus.start_i       = 1'b0;
    bus.icode_i       = 4'h0;
    bus.instr_valid_i = 1'b1;
    bus.imem_ack_i    = 1'b0;
    bus.imem_error_i  = 1'b0;
    bus.dmem_ack_i    = 1'b0;
    bus.dmem_error_i  = 1'b0;
    bus.cnd_i         = 1'b0;
    bus.valC_i        = '0;
    bus.valM_i        = '0;
    bus.valP_i        = '0;

    tick();
    tick();
    rst = 1'b0;
    check("rst_pc", bus.PC_o, 64'h0);
    check("rst_stat", {61'd0, bus.stat_o}, {61'd0, SAOK});
    check("rst_busy", {63'd0, bus.busy_o}, 64'd0);
    check("rst_en", {59'd0, bus.stage_en_o}, 64'd0);
    check("rst_reqs", {62'd0, bus.imem_req_o, bus.dmem_req_o}, 64'd0);
    check("rst_cycles", {32'd0, bus.cycle_cnt_o}, 64'd0);
    check("rst_retired", {32'd0, bus.retired_o}, 64'd0);
    tick();
    check("idle_stays", {63'd0, bus.busy_o}, 64'd0);

    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check("fetch_req", {63'd0, bus.imem_req_o}, 64'd1);

    run_instr(IJXX, 1'b1, 64'd20, 64'h0, 64'h9, 0, 0, 64'd20);
    check("retired_1", {32'd0, bus.retired_o}, 64'd1);
    check("stat_aok", {61'd0, bus.stat_o}, {61'd0, SAOK});
    run_instr(IPUSHQ, 1'b0, 64'h77, 64'h0, 64'd2, 0, 3, 64'd2);
    check("cycles_after_push", {32'd0, bus.cycle_cnt_o}, 64'd14);
    run_instr(IRET, 1'b0, 64'h55, 64'h40, 64'h3, 0, 0, 64'h40);
    run_instr(ICALL, 1'b0, 64'h100, 64'h66, 64'h49, 0, 0, 64'h100);
    check("retired_4", {32'd0, bus.retired_o}, 64'd4);
    run_instr(IJXX, 1'b0, 64'h999, 64'h0, 64'h108, 0, 0, 64'h108);
    run_instr(IOPQ, 1'b1, 64'h123, 64'h456, 64'h10, 2, 0, 64'h10);

    // Halt at 0x10, then confirm start_i cannot wake it.
    bus.icode_i    = IHALT;
    bus.imem_ack_i = 1'b1;
    tick();
    bus.imem_ack_i = 1'b0;
    check("halt_stat", {61'd0, bus.stat_o}, {61'd0, SHLT});
    check("halt_busy", {63'd0, bus.busy_o}, 64'd0);
    check("halt_pc", bus.PC_o, 64'h10);
    check("halt_retired", {32'd0, bus.retired_o}, 64'd6);
    c_hold = bus.cycle_cnt_o;
    for (int i = 0; i < 3; i++) begin
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
      tick();
    end
    check("halt_sticky_stat", {61'd0, bus.stat_o}, {61'd0, SHLT});
    check("halt_sticky_req", {63'd0, bus.imem_req_o}, 64'd0);
    check("halt_cycles_frozen", {32'd0, bus.cycle_cnt_o}, {32'd0, c_hold});

    start_run();
    bus.icode_i    = 4'hC;
    bus.imem_ack_i = 1'b1;
    tick();
    bus.imem_ack_i = 1'b0;
    check("bad_icode_stat", {61'd0, bus.stat_o}, {61'd0, SINS});
    check("bad_icode_en", {59'd0, bus.stage_en_o}, 64'd0);
    check("bad_icode_pc", bus.PC_o, 64'h0);

    start_run();
    bus.icode_i       = IOPQ;
    bus.instr_valid_i = 1'b0;
    bus.imem_ack_i    = 1'b1;
    tick();
    bus.imem_ack_i    = 1'b0;
    bus.instr_valid_i = 1'b1;
    check("invalid_stat", {61'd0, bus.stat_o}, {61'd0, SINS});

    start_run();
    bus.icode_i      = IOPQ;
    bus.imem_error_i = 1'b1;
    bus.imem_ack_i   = 1'b1;
    tick();
    bus.imem_ack_i   = 1'b0;
    bus.imem_error_i = 1'b0;
    check("imem_err_stat", {61'd0, bus.stat_o}, {61'd0, SADR});

    // Data memory that never answers.
    start_run();
    bus.icode_i    = IRMMOVQ;
    bus.imem_ack_i = 1'b1;
    tick();
    bus.imem_ack_i = 1'b0;
    tick();
    tick();
    check("to_in_memory", {63'd0, bus.dmem_req_o}, 64'd1);
    n = 0;
    while (bus.stat_o !== SADR && n < 4 * TO) begin
      tick();
      n++;
    end
    check("timeout_cycles", 64'(n), 64'(TO));
    check("timeout_stat", {61'd0, bus.stat_o}, {61'd0, SADR});
    check("timeout_req_drop", {63'd0, bus.dmem_req_o}, 64'd0);

    // Reset in the middle of a data-memory wait.
    start_run();
    run_instr(INOP, 1'b0, 64'h0, 64'h0, 64'h8, 0, 0, 64'h8);
    bus.icode_i    = IRMMOVQ;
    bus.imem_ack_i = 1'b1;
    tick();
    bus.imem_ack_i = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check("mid_pc", bus.PC_o, 64'h8);
    check("mid_cycles", {32'd0, bus.cycle_cnt_o}, 64'd10);
    check("mid_req", {63'd0, bus.dmem_req_o}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_pc", bus.PC_o, 64'h0);
    check("mid_rst_req", {63'd0, bus.dmem_req_o}, 64'd0);
    check("mid_rst_busy", {63'd0, bus.busy_o}, 64'd0);
    check("mid_rst_cnts", {bus.cycle_cnt_o, bus.retired_o}, 64'd0);
    check("mid_rst_stat", {61'd0, bus.stat_o}, {61'd0, SAOK});

    // Data-memory error arriving together with ack.
    bus.start_i = 1'b1;
    tick();
    bus.start_i    = 1'b0;
    bus.icode_i    = IPOPQ;
    bus.imem_ack_i = 1'b1;
    tick();
    bus.imem_ack_i = 1'b0;
    tick();
    tick();
    bus.dmem_ack_i   = 1'b1;
    bus.dmem_error_i = 1'b1;
    tick();
    bus.dmem_ack_i   = 1'b0;
    bus.dmem_error_i = 1'b0;
    check("dmem_err_stat", {61'd0, bus.stat_o}, {61'd0, SADR});
    check("dmem_err_pc", bus.PC_o, 64'h0);
    check("dmem_err_retired", {32'd0, bus.retired_o}, 64'd0);

    tick();
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

endmodule
